// File: rtl/blockram_reader_if.sv
// Request/response handshake bundle between a read requester and blockram_reader.
interface blockram_reader_if;
    logic        req_valid;
    logic        req_ready;
    logic [18:0] req_addr;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_data;
    logic        resp_last;
    logic        resp_hole;

    modport master (
        output req_valid, req_addr, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_last, resp_hole
    );

    modport slave (
        input  req_valid, req_addr, resp_ready,
        output req_ready, resp_valid, resp_data, resp_last, resp_hole
    );
endinterface

// File: rtl/blockram_reader.sv
// Single-outstanding block RAM read engine with fixed read latency and unmapped-hole tagging.
// Optional BLOCKRAM_READER_BURST_EN: 4-beat critical-word-first wrapping bursts.
module blockram_reader #(
    parameter int READ_LAT  = 1,
    parameter int BURST_LEN = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    blockram_reader_if.slave   bus,
    output logic [16:0]        mem_addr,
    input  logic [31:0]        mem_data
);

    if (READ_LAT < 1 || READ_LAT > 3 || BURST_LEN != 4) begin : g_param_check
        $error("blockram_reader: unsupported READ_LAT or BURST_LEN");
    end

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] RESP  = 2'd3;

    localparam logic [1:0] LAT_LOAD = 2'(READ_LAT - 1);

    logic [1:0]  state;
    logic [1:0]  lat_cnt;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_last;
    logic        out_hole;

`ifdef BLOCKRAM_READER_BURST_EN
    localparam logic [1:0] LAST_BEAT = 2'(BURST_LEN - 1);
    logic [1:0] beat;
`endif

    // Byte-lane bits of the request address carry no meaning for word reads.
    logic unused_addr_bits;
    assign unused_addr_bits = ^bus.req_addr[1:0];

    // Upper half of the map, blocks 0x3..0x8, is not backed by RAM.
    function automatic logic is_hole(input logic [16:0] word);
        return word[16] && (word[15:12] >= 4'h3) && (word[15:12] <= 4'h8);
    endfunction

    assign bus.req_ready  = (state == IDLE) && rst_n;
    assign bus.resp_valid = out_valid;
    assign bus.resp_data  = out_data;
    assign bus.resp_last  = out_last;
    assign bus.resp_hole  = out_hole;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            lat_cnt   <= 2'd0;
            mem_addr  <= 17'd0;
            out_valid <= 1'b0;
            out_data  <= 32'd0;
            out_last  <= 1'b0;
            out_hole  <= 1'b0;
`ifdef BLOCKRAM_READER_BURST_EN
            beat      <= 2'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        mem_addr <= bus.req_addr[18:2];
                        state    <= ISSUE;
`ifdef BLOCKRAM_READER_BURST_EN
                        beat     <= 2'd0;
`endif
                    end
                end
                ISSUE: begin
                    lat_cnt <= LAT_LOAD;
                    state   <= WAIT;
                end
                WAIT: begin
                    if (lat_cnt == 2'd0) begin
                        // mem_addr has been stable since ISSUE, so mem_data belongs to this beat.
                        out_valid <= 1'b1;
                        out_data  <= mem_data;
                        out_hole  <= is_hole(mem_addr);
`ifdef BLOCKRAM_READER_BURST_EN
                        out_last  <= (beat == LAST_BEAT);
`else
                        out_last  <= 1'b1;
`endif
                        state     <= RESP;
                    end else begin
                        lat_cnt <= lat_cnt - 2'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        out_valid <= 1'b0;
`ifdef BLOCKRAM_READER_BURST_EN
                        if (out_last) begin
                            state <= IDLE;
                        end else begin
                            // Wrap inside the 4-word block; upper address bits stay put.
                            mem_addr[1:0] <= mem_addr[1:0] + 2'd1;
                            beat          <= beat + 2'd1;
                            state         <= ISSUE;
                        end
`else
                        state <= IDLE;
`endif
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_blockram_reader.sv
// Self-checking bench: READ_LAT=1 and READ_LAT=3 instances against a word-level reference model.
module tb_blockram_reader;

`ifdef BLOCKRAM_READER_BURST_EN
    localparam int NB = 4;
`else
    localparam int NB = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        req_valid  [2];
    logic        resp_ready [2];
    logic [18:0] req_addr   [2];
    logic        req_ready  [2];
    logic        resp_valid [2];
    logic        resp_last  [2];
    logic        resp_hole  [2];
    logic [31:0] resp_data  [2];
    logic [16:0] mem_addr   [2];
    logic [31:0] mem_data   [2];

    int checks = 0;
    int errors = 0;

    function automatic logic hole_of(input logic [16:0] w);
        return (w[16] == 1'b1) && (w[15:12] >= 4'd3) && (w[15:12] <= 4'd8);
    endfunction

    // Memory contents: unmapped words read 0, one marker word, otherwise an address hash.
    function automatic logic [31:0] memf(input logic [16:0] w);
        if (hole_of(w)) return 32'd0;
        if (w == 17'h00010) return 32'hDEADBEEF;
        return {w[15:0], ~w[15:0]} ^ {15'h1234, w};
    endfunction

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    blockram_reader_if bus [2] ();

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam int L = (g == 0) ? 1 : 3;
        logic [31:0] pipe [3];

        assign bus[g].req_valid  = req_valid[g];
        assign bus[g].req_addr   = req_addr[g];
        assign bus[g].resp_ready = resp_ready[g];
        assign req_ready[g]  = bus[g].req_ready;
        assign resp_valid[g] = bus[g].resp_valid;
        assign resp_data[g]  = bus[g].resp_data;
        assign resp_last[g]  = bus[g].resp_last;
        assign resp_hole[g]  = bus[g].resp_hole;

        always @(posedge clk) begin
            pipe[0] <= memf(mem_addr[g]);
            pipe[1] <= pipe[0];
            pipe[2] <= pipe[1];
        end
        assign mem_data[g] = pipe[L-1];

        blockram_reader #(.READ_LAT(L), .BURST_LEN(4)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .bus      (bus[g]),
            .mem_addr (mem_addr[g]),
            .mem_data (mem_data[g])
        );
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full request on instance d, checking every beat against the model.
    task automatic run_req(input int d, input logic [18:0] a, input int stall_in, input bit early);
        int edges;
        int stall;
        logic busy_rdy;
        logic [16:0] w;
        logic [31:0] hd;
        logic [16:0] ha;
        stall = early ? 0 : stall_in;
        edges = 0;
        while (!req_ready[d] && edges < 50) begin tick(); edges++; end
        chk("req_ready_idle", 32'(req_ready[d]), 32'd1);
        req_valid[d]  = 1'b1;
        req_addr[d]   = a;
        resp_ready[d] = early;
        tick();
        req_valid[d] = 1'b0;
        req_addr[d]  = 19'($urandom);
        for (int i = 0; i < NB; i++) begin
            edges = 0;
            busy_rdy = 1'b0;
            while (!resp_valid[d] && edges < 50) begin
                busy_rdy = busy_rdy | req_ready[d];
                tick();
                edges++;
            end
            w = {a[18:4], 2'(a[3:2] + 2'(i))};
            chk("latency", 32'(edges), 32'(lat_of(d) + 1));
            chk("busy_ready", 32'(busy_rdy), 32'd0);
            chk("mem_addr", 32'(mem_addr[d]), 32'(w));
            chk("resp_data", resp_data[d], memf(w));
            chk("resp_last", 32'(resp_last[d]), 32'(i == NB - 1));
            chk("resp_hole", 32'(resp_hole[d]), 32'(hole_of(w)));
            hd = resp_data[d];
            ha = mem_addr[d];
            for (int s = 0; s < stall; s++) begin
                resp_ready[d] = 1'b0;
                tick();
                chk("stall_hold", 32'(resp_valid[d] && resp_data[d] == hd && mem_addr[d] == ha), 32'd1);
            end
            resp_ready[d] = 1'b1;
            tick();
            if (!early) resp_ready[d] = 1'b0;
            chk("valid_drop", 32'(resp_valid[d]), 32'd0);
        end
        chk("ready_after", 32'(req_ready[d]), 32'd1);
        resp_ready[d] = 1'b0;
    endtask

    // req_valid held high: exactly one accept per completed response.
    task automatic back_to_back(input int d);
        int acc;
        int done;
        int per;
        int edges;
        acc = 0;
        done = 0;
        per = 1 + NB * (lat_of(d) + 2);
        edges = 0;
        while (!req_ready[d] && edges < 50) begin tick(); edges++; end
        req_valid[d]  = 1'b1;
        req_addr[d]   = 19'h00040;
        resp_ready[d] = 1'b1;
        for (int k = 0; k < 60; k++) begin
            if (req_valid[d] && req_ready[d]) acc++;
            if (resp_valid[d] && resp_ready[d] && resp_last[d]) done++;
            tick();
        end
        req_valid[d] = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (resp_valid[d] && resp_ready[d] && resp_last[d]) done++;
            tick();
        end
        resp_ready[d] = 1'b0;
        chk("b2b_accepts", 32'(acc), 32'((60 - 1) / per + 1));
        chk("b2b_done", 32'(done), 32'(acc));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog observed=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [18:0] a;
        int d;
        logic seen;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; resp_ready[i] = 1'b0; req_addr[i] = 19'd0;
        end
        tick(); tick();
        for (int i = 0; i < 2; i++) begin
            chk("rst_req_ready", 32'(req_ready[i]), 32'd0);
            chk("rst_resp_valid", 32'(resp_valid[i]), 32'd0);
            chk("rst_mem_addr", 32'(mem_addr[i]), 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("ready_after_rst", 32'(req_ready[0] && req_ready[1]), 32'd1);

        // Directed: marker word, hole and non-hole upper addresses, long stall, burst start.
        run_req(0, 19'h00040, 0, 1'b1);
        run_req(0, 19'h4C004, 0, 1'b0);
        run_req(0, 19'h7C000, 1, 1'b0);
        run_req(0, 19'h00040, 10, 1'b0);
        run_req(0, 19'h00048, 0, 1'b1);
        run_req(1, 19'h00040, 0, 1'b1);
        run_req(1, 19'h4C004, 2, 1'b0);

        // Reset while instance 0 sits in WAIT.
        run_req(0, 19'h00040, 0, 1'b0);
        req_valid[0] = 1'b1;
        req_addr[0]  = 19'h00044;
        tick();
        req_valid[0] = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_req_ready", 32'(req_ready[0]), 32'd0);
        chk("mid_rst_valid", 32'(resp_valid[0]), 32'd0);
        chk("mid_rst_data", resp_data[0], 32'd0);
        chk("mid_rst_last", 32'(resp_last[0]), 32'd0);
        chk("mid_rst_hole", 32'(resp_hole[0]), 32'd0);
        chk("mid_rst_mem_addr", 32'(mem_addr[0]), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("mid_rst_ready_up", 32'(req_ready[0]), 32'd1);
        resp_ready[0] = 1'b1;
        seen = 1'b0;
        for (int k = 0; k < 8; k++) begin seen = seen | resp_valid[0]; tick(); end
        resp_ready[0] = 1'b0;
        chk("no_beat_after_rst", 32'(seen), 32'd0);
        run_req(0, 19'h00044, 0, 1'b0);

        back_to_back(0);
        back_to_back(1);

        for (int n = 0; n < 24; n++) begin
            d = int'($urandom_range(0, 1));
            a = 19'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                a[18]    = 1'b1;
                a[17:14] = 4'($urandom_range(3, 8));
            end
            run_req(d, a, int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
